seq_mult_signed: RTL and testbench

SEQ_MULT_SIGNED -- requirements
Module: seq_mult_signed

---
 rtl/seq_mult_pkg.sv | 15 +
 rtl/addsub_n.sv | 31 +++
 rtl/seq_mult_signed.sv | 146 ++++++++++++++
 tb/tb_seq_mult_signed.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the sequential signed multiplier.
//   seq_mult_state_t : FSM state encoding (IDLE, ADD, SHIFT, DONE)
//   SEQ_MULT_WIDTH   : default operand width
package seq_mult_pkg;

  localparam int unsigned SEQ_MULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_mult_state_t;

endpackage

// File: rtl/addsub_n.sv
// N-bit ripple-carry adder/subtractor built from full-adder cells.
// Ports:
//   a, b : N-bit operands
//   sub  : 1 = a - b (b inverted, carry-in 1), 0 = a + b
//   sum  : N-bit result, carry-out discarded
module addsub_n #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  localparam int NI = int'(N);

  logic [N-1:0] w_bx;
  logic [N-1:0] w_c;

  assign w_bx   = b ^ {N{sub}};
  assign w_c[0] = sub;

  // Full-adder chain; the top cell produces no carry since it is dropped.
  for (genvar i = 0; i < NI; i++) begin : g_fa
    assign sum[i] = a[i] ^ w_bx[i] ^ w_c[i];
    if (i < NI - 1) begin : g_cy
      assign w_c[i+1] = (a[i] & w_bx[i]) | (w_c[i] & (a[i] ^ w_bx[i]));
    end
  end

endmodule

// File: rtl/seq_mult_signed.sv
// Sequential signed shift-add multiplier. {X,A,B} is shifted right once per
// multiplier bit; the sign bit of the multiplier is handled by subtracting S.
// Optional build macro: SEQ_MULT_SKIP_ZERO_EN -- a zero multiplier bit is
// consumed in a single ADD cycle (the shift is done in place).
// Ports:
//   Clk, Reset    : clock, synchronous active-high reset
//   start         : request, sampled only in IDLE
//   multiplicand  : signed operand S
//   multiplier    : signed operand (loaded into B)
//   busy          : high in ADD and SHIFT
//   done          : one-cycle pulse in DONE
//   product       : {A,B}, valid from DONE until the next acceptance
//   x_bit         : sign-extension register X
module seq_mult_signed
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MULT_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 x_bit
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  seq_mult_state_t  r_state;
  logic             r_x;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic             w_sub;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_last;
  logic [WIDTH-1:0] w_a_shr;
  logic [WIDTH-1:0] w_b_shr;

  // The last iteration weights the multiplier sign bit negatively.
  assign w_sub     = (r_cnt == CW'(WIDTH - 1));
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_last    = (w_cnt_inc == CW'(WIDTH));

  // Arithmetic right shift of {X,A,B}: X is replicated into A's MSB.
  assign w_a_shr = {r_x, r_a[WIDTH-1:1]};
  assign w_b_shr = {r_a[0], r_b[WIDTH-1:1]};

  addsub_n #(
    .N (WIDTH + 1)
  ) u_addsub (
    .a   ({r_a[WIDTH-1], r_a}),
    .b   ({r_s[WIDTH-1], r_s}),
    .sub (w_sub),
    .sum (w_sum)
  );

  // FSM, datapath registers and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_x     <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= 1'b0;
            r_a     <= '0;
            r_b     <= multiplier;
            r_s     <= multiplicand;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end

        ADD: begin
          if (r_b[0]) begin
            r_x     <= w_sum[WIDTH];
            r_a     <= w_sum[WIDTH-1:0];
            r_state <= SHIFT;
          end else begin
`ifdef SEQ_MULT_SKIP_ZERO_EN
            r_a   <= w_a_shr;
            r_b   <= w_b_shr;
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= ADD;
            end
`else
            r_state <= SHIFT;
`endif
          end
        end

        SHIFT: begin
          r_a   <= w_a_shr;
          r_b   <= w_b_shr;
          r_cnt <= w_cnt_inc;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= ADD;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = {r_a, r_b};
  assign x_bit   = r_x;

endmodule

// File: tb/tb_seq_mult_signed.sv
// Self-checking bench for seq_mult_signed (WIDTH=8), both macro builds.
module tb_seq_mult_signed;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;

`ifdef SEQ_MULT_SKIP_ZERO_EN
  localparam int LAT_FD = 16;  // popcount(0xFD)=7
  localparam int LAT_00 = 9;
  localparam int LAT_80 = 10;
  localparam int LAT_7F = 16;
  localparam int LAT_A5 = 13;
`else
  localparam int LAT_FD = 17;
  localparam int LAT_00 = 17;
  localparam int LAT_80 = 17;
  localparam int LAT_7F = 17;
  localparam int LAT_A5 = 17;
`endif

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  mc    = '0;
  logic [W-1:0]  mp    = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] prod;
  logic          xb;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_mult_signed #(
    .WIDTH (W)
  ) dut (
    .Clk          (clk),
    .Reset        (rst),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
    .busy         (busy),
    .done         (done),
    .product      (prod),
    .x_bit        (xb)
  );

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    longint p;
    sa = a;
    sb = b;
    p  = longint'(sa) * longint'(sb);
    return PW'(p);
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
`ifdef SEQ_MULT_SKIP_ZERO_EN
    return int'(W) + $countones(b) + 1;
`else
    return 2 * int'(W) + 1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: cycle index within the current operation (0 = idle).
  int            m_idx  = 0;
  int            m_len  = 0;
  logic [PW-1:0] m_prod = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_idx  = 0;
      m_prod = '0;
    end else if (m_idx == 0) begin
      if (start) begin
        m_prod = ref_mul(mc, mp);
        m_len  = ref_lat(mp);
        m_idx  = 1;
      end
    end else if (m_idx == m_len) begin
      m_idx = 0;
    end else begin
      m_idx++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit ed;
    bit eb;
    if (chk_en) begin
      ed = (m_idx != 0) && (m_idx == m_len);
      eb = (m_idx != 0) && (m_idx < m_len);
      chk("cyc_done", 32'(done), 32'(ed));
      chk("cyc_busy", 32'(busy), 32'(eb));
      if (m_idx == 0 || ed) begin
        chk("cyc_product", 32'(prod), 32'(m_prod));
        chk("cyc_x_bit", 32'(xb), 32'(m_prod[PW-1]));
      end
    end
  end

  // Waits from cycle 1 of an operation until done, bounded.
  task automatic wait_done(output int lat, output bit seen);
    lat  = 1;
    seen = 1'b0;
    while (lat < 200) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One operation from IDLE; optional start pokes while busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [PW-1:0] exp_p, input int exp_lat, input bit poke);
    int lat;
    bit seen;
    mc    = a;
    mp    = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    seen  = 1'b0;
    while (lat < 200) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (poke) begin
        start = (lat == 3 || lat == 4);
        mc    = ~a;
        mp    = ~b;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("op_done_seen", 32'(seen), 32'd1);
    chk("op_latency", 32'(lat), 32'(exp_lat));
    chk("op_product", 32'(prod), 32'(exp_p));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    int n;
    logic [W-1:0] corner [6];
    logic [W-1:0] a;
    logic [W-1:0] b;

    corner[0] = 8'h80; corner[1] = 8'h7F; corner[2] = 8'h00;
    corner[3] = 8'h01; corner[4] = 8'hFF; corner[5] = 8'hC0;

    // Reset, with start asserted to show reset overrides it
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start  = 1'b0;
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("rst_product", 32'(prod), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_x_bit", 32'(xb), 32'd0);

    // Hand-computed pins
    run_op(8'd7,  8'hFD, 16'hFFEB, LAT_FD, 1'b0);
    run_op(8'h80, 8'h80, 16'h4000, LAT_80, 1'b0);
    run_op(8'h80, 8'h7F, 16'hC080, LAT_7F, 1'b0);
    run_op(8'h55, 8'h00, 16'h0000, LAT_00, 1'b0);

    // Start pulsed while busy is ignored
    run_op(8'd7, 8'hFD, 16'hFFEB, LAT_FD, 1'b1);

    // Start held high: second op accepted in the IDLE cycle after DONE
    mc = 8'd7; mp = 8'hFD; start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat, seen);
    chk("b2b_first_seen", 32'(seen), 32'd1);
    chk("b2b_first_latency", 32'(lat), 32'(LAT_FD));
    chk("b2b_first_product", 32'(prod), 32'hFFEB);
    mc = 8'h80; mp = 8'h7F;
    @(posedge clk); #1;
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_product", 32'(prod), 32'hFFEB);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    wait_done(lat, seen);
    chk("b2b_second_seen", 32'(seen), 32'd1);
    chk("b2b_second_latency", 32'(lat), 32'(LAT_7F));
    chk("b2b_second_product", 32'(prod), 32'hC080);
    @(posedge clk); #1;

    // Reset in cycle 5 of an operation aborts it
    mc = 8'h33; mp = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_product", 32'(prod), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    run_op(8'h33, 8'hA5, 16'hEDDF, LAT_A5, 1'b0);

    // Randomized operands with periodic corner values
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 7 == 0) a = corner[$urandom_range(0, 5)];
      if (i % 5 == 0) b = corner[$urandom_range(0, 5)];
      run_op(a, b, ref_mul(a, b), ref_lat(b), 1'b0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
